regfile_wb_arbiter: RTL and testbench

Writeback arbiter for the 32x32 register file's single write port. It accepts writeback results from two producers, the ALU and the load unit. Each producer has its own small queue. The arbiter grants one entry per cycle to the register file write port (wr_en/w1/data). It also exports a pending-destination mask that decode uses for RAW/WAW stall decisions. Load results have priority, and a starvation counter bounds how long ALU results can wait.

---
 rtl/oryx_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oryx_pkg.sv
// Shared register-file definitions: widths, the writeback entry type and the
// destination-to-mask decode used by the pending scoreboard.
package oryx_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Register 0 is hardwired, so it never shows up as pending.
    function automatic logic [31:0] rd_to_mask(input logic [REG_ADDR_W-1:0] rd);
        logic [31:0] mask;
        mask    = 32'd1 << rd;
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of writeback entries; also reports the OR of the
// decoded destinations of every occupied slot.
module wb_fifo
    import oryx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    output wb_entry_t   head,
    output logic        full,
    output logic        empty,
    output logic [31:0] rd_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] offset;
    wb_entry_t        mem [DEPTH];

    // The extra pointer MSB tells a full queue apart from an empty one.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; occupancy comes only from the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // NOTE: defaults first so no path through always_comb infers a latch.
    always_comb begin
        rd_mask = '0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr[PTR_W-1:0];
            if ({1'b0, offset} < count) rd_mask = rd_mask | rd_to_mask(mem[i].rd);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port
// and exports the pending-destination mask used by decode for hazard stalls.
module regfile_wb_arbiter
    import oryx_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] w1,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       pending
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic        ld_full, ld_empty, alu_full, alu_empty;
    logic [31:0] ld_mask, alu_mask;
    wb_entry_t   ld_head, alu_head;
    logic        ld_fire, alu_fire, alu_conflict;
    logic        force_alu, grant_ld, grant_alu;
    logic [WAIT_W-1:0] alu_wait;

    // An ALU result may not queue behind a load to the same register; this
    // keeps per-register write order equal to acceptance order.
    assign alu_conflict = (alu_rd != '0) &&
                          (ld_mask[alu_rd] || (ld_fire && ld_rd == alu_rd));
    assign ld_ready  = !rst && !ld_full;
    assign alu_ready = !rst && !alu_full && !alu_conflict;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;

    assign force_alu = (alu_wait == WAIT_W'(MAX_WAIT)) && !alu_empty;
    assign grant_ld  = !ld_empty && !force_alu;
    assign grant_alu = !alu_empty && (force_alu || ld_empty);

    wb_fifo #(.DEPTH(DEPTH)) u_ld_q (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_fire && ld_rd != '0),
        .push_entry ('{rd: ld_rd, data: ld_data}),
        .pop        (grant_ld),
        .head       (ld_head),
        .full       (ld_full),
        .empty      (ld_empty),
        .rd_mask    (ld_mask)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
        .clk        (clk),
        .rst        (rst),
        .push       (alu_fire && alu_rd != '0),
        .push_entry ('{rd: alu_rd, data: alu_data}),
        .pop        (grant_alu),
        .head       (alu_head),
        .full       (alu_full),
        .empty      (alu_empty),
        .rd_mask    (alu_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wait <= '0;
        end else if (alu_empty || grant_alu) begin
            alu_wait <= '0;
        end else if (alu_wait != WAIT_W'(MAX_WAIT)) begin
            alu_wait <= alu_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en <= 1'b0;
            w1    <= '0;
            data  <= '0;
        end else begin
            wr_en <= grant_ld || grant_alu;
            if (grant_ld) begin
                w1   <= ld_head.rd;
                data <= ld_head.data;
            end else if (grant_alu) begin
                w1   <= alu_head.rd;
                data <= alu_head.data;
            end
        end
    end

    always_comb begin
        pending = ld_mask | alu_mask;
        if (wr_en) pending = pending | rd_to_mask(w1);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes the hand-derived write order into a
// scoreboard queue; a negedge monitor pops and compares every wr_en pulse.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  w1;
    logic [31:0] data;
    logic [31:0] pending;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(2), .MAX_WAIT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .wr_en     (wr_en),
        .w1        (w1),
        .data      (data),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic offer_ld(input logic [4:0] rd, input logic [31:0] d, output int waited);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = d;
        waited   = 0;
        #1;
        while (ld_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("ld_accept_timeout", 32'(waited), 32'd0);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [31:0] d, output int waited);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        waited    = 0;
        #1;
        while (alu_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("alu_accept_timeout", 32'(waited), 32'd0);
        tick();
        alu_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    // Scoreboard monitor: every write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got w1=%0d data=%h, expected no write", w1, data);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", 32'(w1), 32'(e.rd));
                check("wb_data", data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2;
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        tick();
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_w1", 32'(w1), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        rst = 1'b0;
        tick();

        // Single ALU write: queued one cycle, written the next.
        expect_wr(5'd5, 32'hDEADBEEF);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("single_wr_en_early", 32'(wr_en), 32'd0);
        check("single_pending_q", pending, 32'h0000_0020);
        tick();
        check("single_wr_en", 32'(wr_en), 32'd1);
        check("single_w1", 32'(w1), 32'd5);
        check("single_pending_wr", pending, 32'h0000_0020);
        tick();
        check("single_wr_en_off", 32'(wr_en), 32'd0);
        check("single_pending_clr", pending, 32'd0);

        // Same-cycle conflict on rd=7: load first, ALU held until load pops.
        expect_wr(5'd7, 32'h11);
        expect_wr(5'd7, 32'h22);
        ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
        #1;
        check("conf_ld_ready", 32'(ld_ready), 32'd1);
        check("conf_alu_ready0", 32'(alu_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        #1;
        check("conf_alu_ready1", 32'(alu_ready), 32'd0);
        check("conf_pending", pending, 32'h0000_0080);
        tick();
        check("conf_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        drain();
        check("conf_pending_clr", pending, 32'd0);

        // Starvation: continuous loads, ALU rd=9 forced after 3 load grants.
        expect_wr(5'd1, 32'h101);
        expect_wr(5'd2, 32'h102);
        expect_wr(5'd3, 32'h103);
        expect_wr(5'd9, 32'h900);
        expect_wr(5'd4, 32'h104);
        expect_wr(5'd5, 32'h105);
        expect_wr(5'd6, 32'h106);
        fork
            begin
                int wl;
                for (int k = 1; k <= 6; k++) offer_ld(5'(k), 32'h100 + 32'(k), wl);
            end
            begin
                offer_alu(5'd9, 32'h900, w);
                check("starve_alu_wait", 32'(w), 32'd0);
            end
        join
        drain();

        // Full ALU queue: third offer stalls until the first ALU pop.
        expect_wr(5'd10, 32'h20A);
        expect_wr(5'd11, 32'h20B);
        expect_wr(5'd12, 32'h20C);
        expect_wr(5'd20, 32'h214);
        expect_wr(5'd13, 32'h20D);
        expect_wr(5'd14, 32'h20E);
        expect_wr(5'd15, 32'h20F);
        expect_wr(5'd21, 32'h215);
        expect_wr(5'd22, 32'h216);
        fork
            begin
                int wl;
                for (int k = 10; k <= 15; k++) offer_ld(5'(k), 32'h200 + 32'(k), wl);
            end
            begin
                offer_alu(5'd20, 32'h214, w);
                offer_alu(5'd21, 32'h215, w2);
                check("full_first_two_wait", 32'(w + w2), 32'd0);
                offer_alu(5'd22, 32'h216, w);
                check("full_third_wait", 32'(w), 32'd3);
            end
        join
        drain();

        // rd=0 offer: accepted but never written or marked pending.
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        #1;
        check("rd0_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        check("rd0_pending0", pending, 32'd0);
        tick();
        check("rd0_wr_en", 32'(wr_en), 32'd0);
        check("rd0_pending1", pending, 32'd0);
        tick();

        // Reset mid-operation with two entries queued and a write on the port.
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        tick();
        ld_rd = 5'd5; ld_data = 32'h55;
        alu_valid = 1'b0;
        tick();
        ld_valid = 1'b0;
        check("mid_wr_en_before", 32'(wr_en), 32'd1);
        check("mid_pending_before", pending, 32'h0000_0038);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_pending", pending, 32'd0);
        check("mid_rst_w1", 32'(w1), 32'd0);
        check("mid_rst_data", data, 32'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("mid_post_pending", pending, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
